// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the clock set-mode controller: FSM encoding,
// edit-field codes and time-field limits.
package clock_set_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_SET_SEC  = 3'd3,
    ST_COMMIT   = 3'd4
  } state_e;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam logic [7:0] HOUR_MAX = 8'd23;
  localparam logic [7:0] MIN_MAX  = 8'd59;
  localparam logic [7:0] SEC_MAX  = 8'd59;

  function automatic logic [1:0] field_of(input state_e s);
    logic [1:0] f;
    case (s)
      ST_SET_HOUR: f = FIELD_HOUR;
      ST_SET_MIN:  f = FIELD_MIN;
      ST_SET_SEC:  f = FIELD_SEC;
      default:     f = FIELD_NONE;
    endcase
    return f;
  endfunction

  function automatic logic is_set_state(input state_e s);
    logic r;
    case (s)
      ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: r = 1'b1;
      default:                             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_wrap_inc.sv
// Increment-with-wrap for one time field: values at or above the limit
// roll over to zero, so an out-of-range shadow value self-corrects.
module wrap_inc (
  input  logic [7:0] value_i,
  input  logic [7:0] limit_i,
  output logic [7:0] next_o
);

  always_comb begin
    if (value_i >= limit_i) begin
      next_o = 8'd0;
    end else begin
      next_o = value_i + 8'd1;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Set-mode controller for a HH:MM:SS clock: freezes the time counter while
// the user edits shadow fields, then loads them back in one cycle.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  output logic       cnt_en,
  output logic       load,
  output logic [7:0] set_hour,
  output logic [7:0] set_min,
  output logic [7:0] set_sec,
  output logic [1:0] edit_field,
  output logic       blink
);

  localparam logic [6:0] TMO_LIMIT = 7'(TIMEOUT_S);

  state_e     state_q, state_d;
  logic [5:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0] set_hour_q, set_hour_d;
  logic [7:0] set_min_q, set_min_d;
  logic [7:0] set_sec_q, set_sec_d;
  logic       load_q, load_d;
  logic       blink_q, blink_d;
  logic [1:0] edit_field_q, edit_field_d;

  logic [7:0] hour_inc_s, min_inc_s, sec_inc_s;
  logic       btn_any_s;
  logic       timeout_s;

  wrap_inc u_inc_hour (.value_i(set_hour_q), .limit_i(HOUR_MAX), .next_o(hour_inc_s));
  wrap_inc u_inc_min  (.value_i(set_min_q),  .limit_i(MIN_MAX),  .next_o(min_inc_s));
  wrap_inc u_inc_sec  (.value_i(set_sec_q),  .limit_i(SEC_MAX),  .next_o(sec_inc_s));

  // A button in the same cycle as the final tick wins; no timeout then.
  assign btn_any_s = btn_mode | btn_inc;
  assign timeout_s = tick_1hz & ~btn_any_s &
                     (({1'b0, tmo_cnt_q} + 7'd1) >= TMO_LIMIT);

  assign cnt_en = resetn & tick_1hz & (state_q == ST_RUN);

  always_comb begin
    state_d    = state_q;
    set_hour_d = set_hour_q;
    set_min_d  = set_min_q;
    set_sec_d  = set_sec_q;
    case (state_q)
      ST_RUN: begin
        if (btn_mode) begin
          set_hour_d = cur_hour;
          set_min_d  = cur_min;
          set_sec_d  = cur_sec;
          state_d    = ST_SET_HOUR;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SET_HOUR: begin
        if (btn_mode) begin
          state_d = ST_SET_MIN;
        end else if (btn_inc) begin
          set_hour_d = hour_inc_s;
        end else if (timeout_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_SET_HOUR;
        end
      end
      ST_SET_MIN: begin
        if (btn_mode) begin
          state_d = ST_SET_SEC;
        end else if (btn_inc) begin
          set_min_d = min_inc_s;
        end else if (timeout_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_SET_MIN;
        end
      end
      ST_SET_SEC: begin
        if (btn_mode) begin
          state_d = ST_COMMIT;
        end else if (btn_inc) begin
          set_sec_d = sec_inc_s;
        end else if (timeout_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_SET_SEC;
        end
      end
      ST_COMMIT: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Inactivity counter only advances on idle ticks inside the edit states.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (!is_set_state(state_q) || !is_set_state(state_d)) begin
      tmo_cnt_d = 6'd0;
    end else if (btn_any_s) begin
      tmo_cnt_d = 6'd0;
    end else if (tick_1hz) begin
      tmo_cnt_d = tmo_cnt_q + 6'd1;
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Registered outputs are computed from the next state so they track state_q.
  always_comb begin
    load_d       = (state_d == ST_COMMIT);
    edit_field_d = field_of(state_d);
    blink_d      = blink_q;
    if (!is_set_state(state_d)) begin
      blink_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      blink_d = 1'b1;
    end else if (tick_1hz) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_RUN;
      tmo_cnt_q    <= 6'd0;
      set_hour_q   <= 8'd0;
      set_min_q    <= 8'd0;
      set_sec_q    <= 8'd0;
      load_q       <= 1'b0;
      blink_q      <= 1'b0;
      edit_field_q <= FIELD_NONE;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      set_hour_q   <= set_hour_d;
      set_min_q    <= set_min_d;
      set_sec_q    <= set_sec_d;
      load_q       <= load_d;
      blink_q      <= blink_d;
      edit_field_q <= edit_field_d;
    end
  end

  assign load       = load_q;
  assign blink      = blink_q;
  assign edit_field = edit_field_q;
  assign set_hour   = set_hour_q;
  assign set_min    = set_min_q;
  assign set_sec    = set_sec_q;

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_S, default 30: set-mode inactivity timeout in tick_1hz pulses, range 1..63.
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port tick_1hz  input  1  one-cycle pulse, once per second.
REQ-005 SHALL have port btn_mode  input  1  one-cycle pulse, already debounced: enter set mode, or advance to the next field.
REQ-006 SHALL have port btn_inc  input  1  one-cycle pulse, already debounced: increment the field being edited.
REQ-007 SHALL have ports cur_hour, cur_min, cur_sec  input  8 each  live time from the time counter, binary.
REQ-008 SHALL have port cnt_en  output  1  count enable to the time counter.
REQ-009 SHALL have port load  output  1  one-cycle pulse: time counter takes set_hour, set_min, set_sec.
REQ-010 SHALL have ports set_hour, set_min, set_sec  output  8 each  shadow time values (registered).
REQ-011 SHALL have port edit_field  output  2  field being edited: 0 none, 1 hour, 2 min, 3 sec.
REQ-012 SHALL have port blink  output  1  display blink phase for the edited field.

Function
REQ-013 SHALL implement an FSM with states RUN, SET_HOUR, SET_MIN, SET_SEC and COMMIT.
REQ-014 SHALL, in RUN, drive cnt_en = tick_1hz combinationally (same cycle); in every other state SHALL drive cnt_en = 0, so the clock is frozen.
REQ-015 SHALL, in RUN on btn_mode, copy cur_hour/min/sec into the shadow registers and go to SET_HOUR at the next edge.
REQ-016 SHALL make btn_inc increment the shadow value of the field being edited, one step per pulse:
- hour wraps 23->0
- min and sec wrap 59->0
- a shadow value at or above its limit (hour >= 23, min/sec >= 59) wraps to 0.
REQ-017 SHALL step fields on btn_mode: SET_HOUR->SET_MIN->SET_SEC->COMMIT.
REQ-018 SHALL, in COMMIT, assert load for exactly one cycle while holding the shadow values stable, then return to RUN.
REQ-019 SHALL act on btn_mode only when btn_mode and btn_inc occur in the same cycle; btn_inc is discarded.
REQ-020 SHALL count tick_1hz pulses in the SET_* states:
- the counter is cleared on any button pulse and on entry to SET_HOUR
- when the count reaches TIMEOUT_S, the FSM returns to RUN with no load pulse and the shadow values discarded.
REQ-021 SHALL resolve a timeout tick and a button in the same cycle in favour of the button; no timeout occurs that cycle.
REQ-022 SHALL ignore btn_inc in RUN and ignore both buttons in COMMIT.
REQ-023 SHALL set blink to 1 on SET_HOUR entry and toggle it on each tick_1hz while in a SET_* state; blink SHALL be 0 in RUN and COMMIT.
REQ-024 SHALL drive edit_field from the state: 1, 2 or 3 in SET_HOUR, SET_MIN or SET_SEC; 0 in RUN and COMMIT.
REQ-025 SHALL ignore a tick_1hz arriving in COMMIT; that second is lost and is not counted.

Reset
REQ-026 SHALL, while resetn = 0, immediately force:
- state RUN
- load 0, blink 0, edit_field 0
- set_hour, set_min, set_sec 0
- timeout counter 0.
REQ-027 SHALL, on reset in any SET_* state or in COMMIT, produce no load pulse; the time counter is reset separately by the same resetn.
REQ-028 SHALL hold cnt_en = 0 while resetn = 0.

Structure
REQ-029 SHALL take the following from the shared clock package: the state encoding, the field codes 0..3, and the constants HOUR_MAX = 23 and MIN_MAX = SEC_MAX = 59.
REQ-030 SHALL use one sub-module, wrap_inc (8-bit value plus limit -> incremented value with wrap), instanced three times.
REQ-031 SHALL register all outputs except cnt_en.

Verification
REQ-032 SHALL cover the run path: no buttons, 5 tick_1hz pulses -> cnt_en high in exactly those 5 cycles; load never asserted.
REQ-033 SHALL cover a full set cycle: cur = 10:20:30; mode, inc x3, mode, inc x45, mode, inc x0, mode -> one load pulse with 13:05:30; edit_field sequence 1, 2, 3, 0.
REQ-034 SHALL cover hour wrap: enter set at cur_hour = 22, inc x3 -> set_hour 1.
REQ-035 SHALL cover timeout with TIMEOUT_S = 3: enter set, 3 ticks and no buttons -> back in RUN, no load, cnt_en resumes on the next tick; repeat with an inc on the 2nd tick -> still in SET_HOUR after the 3rd tick.
REQ-036 SHALL cover a simultaneous press: btn_mode and btn_inc together in SET_MIN -> moves to SET_SEC with set_min unchanged.
REQ-037 SHALL cover reset mid-operation: resetn low while in SET_SEC -> outputs at their reset values at once, no load, RUN after release.
